// File: rtl/seq_alu.sv
// seq_alu: sequential RISC-V style ALU with a ready/valid request and result handshake.
//   Optional RV32M multiply/divide unit, built only when SEQ_ALU_MULDIV_EN is defined.
//   clk        : single clock, rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   : request present        in_ready : request accepted when both high
//   op1, op2   : WIDTH-bit operands
//   opcode, funct3, funct7 : RISC-V encoding fields, sampled on accept
//   out_valid  : result available (DONE) out_ready : consumer takes the result
//   result     : registered result       zero : result == 0
//   illegal    : accepted encoding unsupported (result forced to 0)
module seq_alu #(
   parameter int WIDTH          = 32,
   parameter int DIV_RADIX_BITS = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic [6:0]       funct7,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             illegal
);
   localparam int SW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
   state_t state, state_nx;
   logic accept, is_r, is_i, f7_std, base_ok, go_mul, go_div, div_last;
   logic [SW-1:0] shamt;
   logic [WIDTH-1:0] alu, sra_v;
   assign in_ready  = state == IDLE || (state == DONE && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = state == DONE;
   assign zero      = result == '0;
   assign is_r      = opcode == 7'b0110011;
   assign is_i      = opcode == 7'b0010011;
   assign f7_std    = funct7 == 7'b0000000 || funct7 == 7'b0100000;
   // ITYPE funct7 is immediate data except for the shift-right encodings
   assign base_ok   = (is_r && f7_std) || (is_i && (funct3 != 3'b101 || f7_std));
   assign shamt     = op2[SW-1:0];
   assign sra_v     = $signed(op1) >>> shamt;
   always_comb begin
      alu = '0;
      case (funct3)
         3'b000:  alu = (is_r && funct7[5]) ? op1 - op2 : op1 + op2;
         3'b001:  alu = op1 << shamt;
         3'b010:  alu = {{(WIDTH-1){1'b0}}, $signed(op1) < $signed(op2)};
         3'b011:  alu = {{(WIDTH-1){1'b0}}, op1 < op2};
         3'b100:  alu = op1 ^ op2;
         3'b101:  alu = funct7[5] ? sra_v : op1 >> shamt;
         3'b110:  alu = op1 | op2;
         default: alu = op1 & op2;
      endcase
   end
`ifdef SEQ_ALU_MULDIV_EN
   localparam int ITER = WIDTH / DIV_RADIX_BITS;
   localparam int CW   = $clog2(ITER);
   logic md, sgn, a_neg, b_neg, div0, ovf, a_sx, b_sx, mul_hi, d_negq, d_negr, d_isrem;
   logic [WIDTH-1:0] a_mag, b_mag, nq, q_fin, r_fin, d_quo, d_div;
   logic [WIDTH:0] nr, d_rem;
   logic [2*WIDTH-1:0] mul_a, mul_b, prod;
   logic [CW-1:0] d_cnt;
   assign md       = is_r && funct7 == 7'b0000001;
   assign sgn      = !funct3[0];
   assign a_neg    = sgn && op1[WIDTH-1];
   assign b_neg    = sgn && op2[WIDTH-1];
   assign a_mag    = a_neg ? -op1 : op1;
   assign b_mag    = b_neg ? -op2 : op2;
   assign div0     = op2 == '0;
   assign ovf      = sgn && op1 == {1'b1, {(WIDTH-1){1'b0}}} && op2 == '1;
   // MULH and MULHSU sign-extend op1; only MULH sign-extends op2
   assign a_sx     = (funct3[1] ^ funct3[0]) && op1[WIDTH-1];
   assign b_sx     = funct3[1:0] == 2'b01 && op2[WIDTH-1];
   assign go_mul   = md && !funct3[2];
   assign go_div   = md && funct3[2] && !div0 && !ovf;
   assign div_last = d_cnt == '0;
   assign prod     = mul_a * mul_b;
   // restoring divider: the dividend shifts out of d_quo into the partial remainder
   always_comb begin
      nr = d_rem;
      nq = d_quo;
      for (int i = 0; i < DIV_RADIX_BITS; i++) begin
         nr = {nr[WIDTH-1:0], nq[WIDTH-1]};
         nq = {nq[WIDTH-2:0], 1'b0};
         if (nr >= {1'b0, d_div}) begin
            nr    = nr - {1'b0, d_div};
            nq[0] = 1'b1;
         end
      end
   end
   assign q_fin = d_negq ? -nq : nq;
   assign r_fin = d_negr ? -nr[WIDTH-1:0] : nr[WIDTH-1:0];
`else
   assign go_mul   = 1'b0;
   assign go_div   = 1'b0;
   assign div_last = 1'b1;
`endif
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      state_nx = accept ? (go_mul ? MUL : go_div ? DIV : DONE) :
                 (state == DONE && out_ready) ? IDLE :
                 (state == MUL || (state == DIV && div_last)) ? DONE : state;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         result  <= '0;
         illegal <= 1'b0;
      end else if (accept) begin
         result  <= base_ok ? alu : '0;
         illegal <= !base_ok;
`ifdef SEQ_ALU_MULDIV_EN
         // operand staging is harmless for ops that never enter MUL or DIV
         mul_a   <= {{WIDTH{a_sx}}, op1};
         mul_b   <= {{WIDTH{b_sx}}, op2};
         mul_hi  <= funct3[1:0] != 2'b00;
         d_rem   <= '0;
         d_quo   <= a_mag;
         d_div   <= b_mag;
         d_cnt   <= CW'(ITER - 1);
         d_negq  <= a_neg ^ b_neg;
         d_negr  <= a_neg;
         d_isrem <= funct3[1];
         if (md) begin
            illegal <= 1'b0;
            // divide-by-zero and signed overflow finish immediately; MUL and
            // iterating divides overwrite this before reaching DONE
            result  <= funct3[1] ? (ovf ? '0 : op1) : (ovf ? op1 : '1);
         end
`endif
      end
`ifdef SEQ_ALU_MULDIV_EN
      else if (state == MUL) begin
         result  <= mul_hi ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
         illegal <= 1'b0;
      end else if (state == DIV) begin
         d_rem <= nr;
         d_quo <= nq;
         d_cnt <= d_cnt - 1'b1;
         if (div_last) begin
            result  <= d_isrem ? r_fin : q_fin;
            illegal <= 1'b0;
         end
      end
`endif
   end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: randomized self-checking bench for seq_alu against an arithmetic reference model.
module tb_seq_alu;
   logic clk = 1'b0, rst_n, in_valid, in_ready, out_valid, out_ready, zero, illegal;
   logic [31:0] op1, op2, result;
   logic [6:0] opcode, funct7;
   logic [2:0] funct3;
   int n_checks = 0, n_errors = 0;
   always #5 clk = ~clk;
   seq_alu dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op1(op1), .op2(op2), .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .zero(zero), .illegal(illegal)
   );
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   function automatic void ref_op(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic il, output int lat);
      logic [63:0] p;
      r = 0; il = 0; lat = 1;
      if (opc == 7'h33 && f7 == 7'h01) begin
`ifdef SEQ_ALU_MULDIV_EN
         case (f3)
            3'd0: begin r = a * b; lat = 2; end
            3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[63:32]; lat = 2; end
            3'd2: begin p = {{32{a[31]}}, a} * {32'd0, b}; r = p[63:32]; lat = 2; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; lat = 2; end
            default: begin
               if (b == 0) r = f3[1] ? a : 32'hFFFFFFFF;
               else if (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) r = f3[1] ? 0 : a;
               else begin
                  lat = 33;
                  if (f3[0]) r = f3[1] ? a % b : a / b;
                  else if (f3[1]) r = $signed(a) % $signed(b);
                  else r = $signed(a) / $signed(b);
               end
            end
         endcase
`else
         il = 1;
`endif
      end else if ((opc == 7'h33 && (f7 == 0 || f7 == 7'h20)) ||
                   (opc == 7'h13 && (f3 != 5 || f7 == 0 || f7 == 7'h20))) begin
         case (f3)
            3'd0: r = (opc == 7'h33 && f7 == 7'h20) ? a - b : a + b;
            3'd1: r = a << b[4:0];
            3'd2: r = ($signed(a) < $signed(b)) ? 1 : 0;
            3'd3: r = (a < b) ? 1 : 0;
            3'd4: r = a ^ b;
            3'd5: if (f7 == 7'h20) r = $signed(a) >>> b[4:0]; else r = a >> b[4:0];
            3'd6: r = a | b;
            default: r = a & b;
         endcase
      end else il = 1;
   endfunction
   task automatic do_op(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b, input int hold,
                        output logic [31:0] got);
      logic [31:0] er;
      logic eil;
      int elat, n;
      ref_op(opc, f3, f7, a, b, er, eil, elat);
      opcode = opc; funct3 = f3; funct7 = f7; op1 = a; op2 = b;
      in_valid = 1; out_ready = (hold == 0);
      n = 0;
      while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
      if (!in_ready) check("in_ready_timeout", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 0;
      n = 1;
      while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
      check("latency", n, elat);
      check("result", result, er);
      check("illegal", illegal, eil);
      check("zero", zero, er == 0);
      got = result;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("hold_valid", out_valid, 1);
         check("hold_result", result, er);
         check("hold_in_ready", in_ready, 0);
      end
      out_ready = 1;
      @(posedge clk); #1;
      check("drained", out_valid, 0);
   endtask
   function automatic logic [31:0] rnd_operand();
      case ($urandom_range(0, 5))
         0: return 0;
         1: return 32'hFFFFFFFF;
         2: return 32'h80000000;
         3: return $urandom_range(0, 15);
         default: return $urandom;
      endcase
   endfunction
   initial begin
      logic [31:0] got, er, a, b;
      logic [6:0] opc, f7;
      logic [2:0] f3;
      logic eil;
      int elat, n, seen;
      rst_n = 0; in_valid = 0; out_ready = 0; op1 = 0; op2 = 0;
      opcode = 0; funct3 = 0; funct7 = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_result", result, 0);
      check("rst_zero", zero, 1);
      check("rst_illegal", illegal, 0);
      rst_n = 1;
      @(posedge clk); #1;
      check("rst_in_ready", in_ready, 1);
      do_op(7'h33, 3'd0, 7'h00, 5, 7, 0, got);
      check("add_5_7", got, 12);
      check("add_in_ready", in_ready, 1);
      do_op(7'h33, 3'd5, 7'h20, 32'h80000000, 4, 3, got);
      check("sra", got, 32'hF8000000);
      do_op(7'h13, 3'd5, 7'h10, 32'h80000000, 4, 0, got);
      check("srli_bad_f7", illegal, 1);
      do_op(7'h7F, 3'd0, 7'h00, 1, 2, 0, got);
      check("bad_opcode_res", got, 0);
`ifdef SEQ_ALU_MULDIV_EN
      do_op(7'h33, 3'd5, 7'h01, 100, 7, 0, got);
      check("divu", got, 14);
      do_op(7'h33, 3'd6, 7'h01, -100, 7, 1, got);
      check("rem_neg", got, -2);
      do_op(7'h33, 3'd4, 7'h01, 5, 0, 0, got);
      check("div_zero", got, 32'hFFFFFFFF);
      do_op(7'h33, 3'd4, 7'h01, 32'h80000000, 32'hFFFFFFFF, 0, got);
      check("div_ovf", got, 32'h80000000);
      do_op(7'h33, 3'd7, 7'h01, 9, 0, 0, got);
      check("remu_zero", got, 9);
      do_op(7'h33, 3'd1, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, got);
      check("mulh", got, 0);
      do_op(7'h33, 3'd3, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, got);
      check("mulhu", got, 32'hFFFFFFFE);
      opcode = 7'h33; funct3 = 3'd5; funct7 = 7'h01; op1 = 1000; op2 = 3; in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 0;
      @(posedge clk); #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 1);
      rst_n = 1;
      seen = 0;
      repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
      check("midrst_no_result", seen, 0);
`else
      do_op(7'h33, 3'd0, 7'h01, 3, 4, 0, got);
      check("mul_disabled_res", got, 0);
      check("mul_disabled_ill", illegal, 1);
`endif
      out_ready = 1;
      opcode = 7'h33; funct3 = 3'd0; funct7 = 7'h00; op1 = 1; op2 = 2; in_valid = 1;
      @(posedge clk); #1;
      check("b2b_first", result, 3);
      op1 = 10; op2 = 20;
      check("b2b_in_ready", in_ready, 1);
      @(posedge clk); #1;
      check("b2b_valid", out_valid, 1);
      check("b2b_second", result, 30);
      funct3 = 3'd3; funct7 = 7'h01; op1 = 32'hFFFFFFFF; op2 = 32'hFFFFFFFF;
      ref_op(7'h33, 3'd3, 7'h01, op1, op2, er, eil, elat);
      @(posedge clk); #1;
      in_valid = 0;
      n = 1;
      while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
      check("b2b_third_lat", n, elat);
      check("b2b_third_res", result, er);
      @(posedge clk); #1;
      for (int t = 0; t < 200; t++) begin
         a = rnd_operand(); b = rnd_operand();
         f3 = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 9))
            0, 1, 2, 3: begin
               opc = 7'h33;
               f7 = ((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            end
            4, 5: begin
               opc = 7'h13;
               f7 = (f3 == 5) ? ($urandom_range(0, 1) == 1 ? 7'h20 : 7'h00) :
                    (f3 == 1) ? 7'h00 : 7'($urandom_range(0, 127));
            end
            6, 7, 8: begin opc = 7'h33; f7 = 7'h01; end
            default: begin
               opc = 7'($urandom_range(0, 127));
               f7 = 7'($urandom_range(0, 127));
               if (f7 == 0 || f7 == 1 || f7 == 7'h20) f7 = 7'h7F;
               if (opc == 7'h33 || opc == 7'h13) f3 = 3'd5;
            end
         endcase
         do_op(opc, f3, f7, a, b, $urandom_range(0, 2), got);
      end
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; legal values are even and >= 8.
REQ-002 SHALL have parameter DIV_RADIX_BITS, default 1, quotient bits resolved per divide iteration; legal values are 1 or 2, and WIDTH is divisible by it.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  request accepted this cycle when both in_valid and in_ready are high.
REQ-007 SHALL have ports op1, op2  input  WIDTH  operands.
REQ-008 SHALL have ports opcode, funct3, funct7  input  7, 3, 7  RISC-V encoding fields, sampled on accept.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result when both out_valid and out_ready are high.
REQ-011 SHALL have port result  output  WIDTH  registered result.
REQ-012 SHALL have port zero  output  1  high when result equals 0.
REQ-013 SHALL have port illegal  output  1  high when the accepted encoding is unsupported; result is 0 in that case.

Function
REQ-014 SHALL implement the FSM states IDLE, MUL, DIV and DONE.
REQ-015 in_ready SHALL equal (state==IDLE) or (state==DONE and out_ready).
REQ-016 out_valid SHALL be high only in DONE.
REQ-017 result, zero and illegal SHALL stay stable in DONE until the output handshake completes.
REQ-018 When the output handshake completes and no new request is accepted in the same cycle, the FSM SHALL go DONE->IDLE.
REQ-019 When the output handshake completes and a new request is accepted in the same cycle, the FSM SHALL start the new operation with no bubble.
REQ-020 RTYPE with funct7 0000000/0100000, and ITYPE, SHALL support ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT and SLTU.
REQ-021 Shift amounts SHALL use the low clog2(WIDTH) bits of op2.
REQ-022 Single-cycle ops SHALL go from accept at cycle N to DONE, with out_valid high at N+1.
REQ-023 ITYPE with funct3 SRL and funct7 other than 0000000/0100000 SHALL set illegal.
REQ-024 RTYPE with funct7 0000001 SHALL decode RV32M ops: funct3 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-025 Multiply ops SHALL pass through the MUL state: operands registered, 2*WIDTH-bit product registered, out_valid at N+2.
REQ-026 MUL SHALL return the low half of the product; the MULH variants SHALL return the high half with the given operand signedness.
REQ-027 Divide ops SHALL use an iterative restoring divider over magnitudes, resolving DIV_RADIX_BITS quotient bits per cycle.
REQ-028 Signed divide results SHALL be sign-corrected: quotient negated when the operand signs differ, remainder takes the dividend's sign.
REQ-029 Divide ops SHALL give out_valid at N+1+WIDTH/DIV_RADIX_BITS.
REQ-030 Divide by zero SHALL return quotient all-ones and remainder op1, with out_valid at N+1.
REQ-031 Signed overflow (op1 = -2^(WIDTH-1), op2 = -1) SHALL return quotient op1 and remainder 0, with out_valid at N+1.
REQ-032 Any other opcode or funct7 SHALL set illegal, with out_valid at N+1.
REQ-033 in_valid with in_ready low SHALL be ignored; the upstream holds its request.
REQ-034 zero SHALL be computed from the registered result.

Reset
REQ-035 While rst_n is low at a clk edge, the block SHALL go to state IDLE and drive out_valid=0, result=0, zero=1, illegal=0; in_ready is 1 after the first clk edge with rst_n high.
REQ-036 Reset mid-divide or mid-multiply SHALL discard the operation; no out_valid is produced for it.

Configuration
REQ-037 Macro SEQ_ALU_MULDIV_EN defined: REQ-024 to REQ-031 apply; the MUL and DIV states exist.
REQ-038 Macro SEQ_ALU_MULDIV_EN undefined: no multiplier or divider hardware; funct7 0000001 SHALL be treated as illegal, with out_valid at N+1.

Verification
REQ-039 Reset then ADD 5+7 with out_ready=1 -> out_valid at N+1, result=12, zero=0, in_ready high on the next cycle.
REQ-040 SRA 0x80000000 by 4, out_ready held low 3 cycles -> result 0xF8000000 stable throughout, in_ready low until the output handshake.
REQ-041 DIVU 100/7 at WIDTH=32, DIV_RADIX_BITS=1 -> out_valid at N+33, result 14; REM -100/7 -> result -2.
REQ-042 DIV 5/0 -> 0xFFFFFFFF at N+1; DIV 0x80000000/-1 -> 0x80000000 at N+1; REMU 9/0 -> 9.
REQ-043 MULH 0xFFFFFFFF*0xFFFFFFFF -> 0; MULHU of the same operands -> 0xFFFFFFFE, out_valid at N+2; back-to-back requests with out_ready=1 -> no bubble.
REQ-044 rst_n low 1 cycle mid-DIV -> IDLE, no out_valid for that divide; a build without SEQ_ALU_MULDIV_EN gets MUL -> illegal=1, result=0.
